// File: rtl/vga_pkg.sv
// Shared VGA scan constants (640x480@60 defaults) and the control word that
// travels alongside each pixel fetch through the read-latency delay line.
package vga_pkg;
   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 751;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 491;
   localparam int CNT_W        = 10;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic in_img;
      logic fstart;
      logic border;
   } scan_ctl_t;
endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with raw sync, image-region and frame-start flags.
// Flags are combinational from the counter registers; the counter itself never stalls.
module vga_timing_counter import vga_pkg::*; #(
   parameter int H_TOT    = H_TOTAL,
   parameter int H_ACT    = 640,
   parameter int HS_START = H_SYNC_START,
   parameter int HS_END   = H_SYNC_END,
   parameter int V_TOT    = V_TOTAL,
   parameter int V_ACT    = 480,
   parameter int VS_START = V_SYNC_START,
   parameter int VS_END   = V_SYNC_END,
   parameter int X0       = 192,
   parameter int Y0       = 112,
   parameter int W        = 256,
   parameter int HGT      = 256
) (
   input  logic      clk,
   input  logic      rst,
   output scan_ctl_t ctl
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] HSS    = CNT_W'(HS_START);
   localparam logic [CNT_W-1:0] HSE    = CNT_W'(HS_END);
   localparam logic [CNT_W-1:0] VSS    = CNT_W'(VS_START);
   localparam logic [CNT_W-1:0] VSE    = CNT_W'(VS_END);
   localparam logic [CNT_W-1:0] HACT   = CNT_W'(H_ACT);
   localparam logic [CNT_W-1:0] VACT   = CNT_W'(V_ACT);
   localparam logic [CNT_W-1:0] XL     = CNT_W'(X0);
   localparam logic [CNT_W-1:0] XR     = CNT_W'(X0 + W);
   localparam logic [CNT_W-1:0] YT     = CNT_W'(Y0);
   localparam logic [CNT_W-1:0] YB     = CNT_W'(Y0 + HGT);
`ifdef VGA_BORDER_EN
   localparam logic [CNT_W-1:0] XLM1   = CNT_W'(X0 - 1);
   localparam logic [CNT_W-1:0] YTM1   = CNT_W'(Y0 - 1);
`endif

   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic             visible;

   always_ff @(posedge clk) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
      end else begin
         h <= h + CNT_W'(1);
      end
   end

   assign visible = (h < HACT) && (v < VACT);

   always_comb begin
      ctl.hs_n   = !((h >= HSS) && (h <= HSE));
      ctl.vs_n   = !((v >= VSS) && (v <= VSE));
      ctl.in_img = visible && (h >= XL) && (h < XR) && (v >= YT) && (v < YB);
      ctl.fstart = (h == '0) && (v == '0);
      ctl.border = 1'b0;
`ifdef VGA_BORDER_EN
      // One-pixel frame hugging the image, including its four corners.
      ctl.border = visible &&
         ((((h == XLM1) || (h == XR)) && (v >= YTM1) && (v <= YB)) ||
          (((v == YTM1) || (v == YB)) && (h >= XLM1) && (h <= XR)));
`endif
   end

endmodule

// File: rtl/vga_frame_scanner.sv
// Scans an 8-bit gray image out to VGA pins; counter-to-pin latency RD_LAT+2, memory never stalls.
// Define VGA_BORDER_EN to draw a white 1-pixel ring around the image (no extra reads).
module vga_frame_scanner import vga_pkg::*; #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int IMG_W     = 256,
   parameter int IMG_H     = 256,
   parameter int IMG_X0    = 192,
   parameter int IMG_Y0    = 112,
   parameter int IMG0_BASE = 0,
   parameter int IMG1_BASE = 65536,
   parameter int ADDR_W    = 17,
   parameter int RD_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              image_select,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              hsync,
   output logic              vsync,
   output logic [23:0]       rgb_out,
   output logic              frame_start
);

   localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(IMG0_BASE);
   localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(IMG1_BASE);
   localparam scan_ctl_t IDLE = '{hs_n: 1'b1, vs_n: 1'b1, in_img: 1'b0, fstart: 1'b0, border: 1'b0};

   scan_ctl_t               ctl0;
   scan_ctl_t [RD_LAT:0]    pipe;
   scan_ctl_t               tail;
   logic [ADDR_W-1:0]       ptr;
   logic [ADDR_W-1:0]       cur;

   vga_timing_counter #(
      .H_TOT    (H_ACTIVE + H_FP + H_SYNC + H_BP),
      .H_ACT    (H_ACTIVE),
      .HS_START (H_ACTIVE + H_FP),
      .HS_END   (H_ACTIVE + H_FP + H_SYNC - 1),
      .V_TOT    (V_ACTIVE + V_FP + V_SYNC + V_BP),
      .V_ACT    (V_ACTIVE),
      .VS_START (V_ACTIVE + V_FP),
      .VS_END   (V_ACTIVE + V_FP + V_SYNC - 1),
      .X0       (IMG_X0),
      .Y0       (IMG_Y0),
      .W        (IMG_W),
      .HGT      (IMG_H)
   ) u_timing (
      .clk (clk),
      .rst (rst),
      .ctl (ctl0)
   );

   // Image rows are stored back to back, so one running pointer covers the whole
   // frame; it is reloaded from image_select only at the raster origin.
   assign cur = ctl0.fstart ? (image_select ? BASE1 : BASE0) : ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= BASE0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
      end else begin
         mem_rd <= ctl0.in_img;
         if (ctl0.in_img) begin
            mem_addr <= cur;
            ptr      <= cur + ADDR_W'(1);
         end else begin
            ptr <= cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pipe <= {(RD_LAT + 1){IDLE}};
      else     pipe <= {pipe[RD_LAT-1:0], ctl0};
   end

   assign tail = pipe[RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         rgb_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= tail.hs_n;
         vsync       <= tail.vs_n;
         frame_start <= tail.fstart;
         if (en && tail.in_img)      rgb_out <= {3{mem_data}};
         else if (en && tail.border) rgb_out <= 24'hFFFFFF;
         else                        rgb_out <= '0;
      end
   end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: full 800-clock lines with a shortened 22-line frame and a 256x6
// image, random en/image_select, checked every cycle against a raster-arithmetic reference.
module tb_vga_frame_scanner;
   localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
   localparam int V_ACTIVE = 16, V_FP = 2, V_SYNC = 2, V_BP = 2;
   localparam int IMG_W = 256, IMG_H = 6, IMG_X0 = 192, IMG_Y0 = 5;
   localparam int IMG0_BASE = 0, IMG1_BASE = 65536, ADDR_W = 17, RD_LAT = 2;
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME = HT * VT;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              image_select;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              hsync;
   logic              vsync;
   logic [23:0]       rgb_out;
   logic              frame_start;

   vga_frame_scanner #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
      .IMG0_BASE(IMG0_BASE), .IMG1_BASE(IMG1_BASE), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .image_select(image_select),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int   errs = 0;
   int   checks = 0;
   int   n = 0;
   bit   valid = 0;
   bit   rst_prev = 1;
   bit   en_prev = 0;
   bit   sel_prev = 0;
   bit   ff_mode = 0;
   logic [7:0] salt = 8'h00;

   function automatic logic [7:0] mem_fn(input logic [ADDR_W-1:0] a);
      if (ff_mode) return 8'hFF;
      if (a == '0) return 8'h5A;
      return a[7:0] ^ a[15:8] ^ (a[16] ? 8'hC3 : 8'h00) ^ salt;
   endfunction

   // Memory: data for the address presented in cycle s appears in cycle s+2.
   logic [ADDR_W-1:0] rd_addr_d;
   always @(posedge clk) begin
      rd_addr_d <= mem_addr;
      mem_data  <= mem_fn(rd_addr_d);
   end

   function automatic int hpos(input int m); return m % HT; endfunction
   function automatic int vpos(input int m); return (m / HT) % VT; endfunction
   function automatic bit img_at(input int m);
      return hpos(m) >= IMG_X0 && hpos(m) < IMG_X0 + IMG_W &&
             vpos(m) >= IMG_Y0 && vpos(m) < IMG_Y0 + IMG_H;
   endfunction
`ifdef VGA_BORDER_EN
   function automatic bit ring_at(input int m);
      int h = hpos(m);
      int v = vpos(m);
      bit col = (h == IMG_X0 - 1 || h == IMG_X0 + IMG_W) && v >= IMG_Y0 - 1 && v <= IMG_Y0 + IMG_H;
      bit row = (v == IMG_Y0 - 1 || v == IMG_Y0 + IMG_H) && h >= IMG_X0 - 1 && h <= IMG_X0 + IMG_W;
      return col || row;
   endfunction
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, n, act, exp);
      end
   endtask

   logic [7:0]        exp_q[$];
   logic [ADDR_W-1:0] last_addr;
   int  base;
   int  hs_last, fs_last, vs_cnt;
   bit  hs_p, vs_p;

   always @(negedge clk) begin
      int m;
      logic [ADDR_W-1:0] a;
      logic [7:0]  b;
      logic [23:0] e_rgb;
      bit e_hs, e_vs, e_fs, e_in, e_bd;
      if (rst_prev) begin
         n = 0; valid = 1; exp_q.delete(); last_addr = '0; base = IMG0_BASE;
         hs_last = -1; fs_last = -1; vs_cnt = 0; hs_p = 1; vs_p = 1;
      end else if (valid) begin
         n++;
      end
      if (valid) begin
         // Fetch side: counter value n-1 drives this cycle's mem_rd/mem_addr.
         if (n >= 1 && hpos(n-1) == 0 && vpos(n-1) == 0) base = sel_prev ? IMG1_BASE : IMG0_BASE;
         if (n >= 1 && img_at(n-1)) begin
            a = ADDR_W'(base + (vpos(n-1) - IMG_Y0) * IMG_W + (hpos(n-1) - IMG_X0));
            last_addr = a;
            exp_q.push_back(mem_fn(a));
         end
         // Pin side: counter value n-4 reaches the outputs this cycle.
         e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = '0;
         if (n >= 4) begin
            m = n - 4;
            e_hs = !(hpos(m) >= H_ACTIVE + H_FP && hpos(m) < H_ACTIVE + H_FP + H_SYNC);
            e_vs = !(vpos(m) >= V_ACTIVE + V_FP && vpos(m) < V_ACTIVE + V_FP + V_SYNC);
            e_fs = (hpos(m) == 0 && vpos(m) == 0);
            e_in = img_at(m);
            e_bd = 0;
`ifdef VGA_BORDER_EN
            e_bd = ring_at(m);
`endif
            b = 8'h00;
            if (e_in && exp_q.size() > 0) b = exp_q.pop_front();
            if (en_prev && e_in)      e_rgb = {b, b, b};
            else if (en_prev && e_bd) e_rgb = 24'hFFFFFF;
         end
         chk("hsync", 32'(hsync), 32'(e_hs));
         chk("vsync", 32'(vsync), 32'(e_vs));
         chk("frame_start", 32'(frame_start), 32'(e_fs));
         chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
         chk("mem_rd", 32'(mem_rd), 32'(n >= 1 && img_at(n-1)));
         chk("mem_addr", 32'(mem_addr), 32'(last_addr));

         // Hand-derived landmarks for this geometry.
         if (n == 4)     chk("first_frame_start", 32'(frame_start), 32'd1);
         if (n == 659)   chk("hs_before_low", 32'(hsync), 32'd1);
         if (n == 660)   chk("hs_first_low", 32'(hsync), 32'd0);
         if (n == 755)   chk("hs_last_low", 32'(hsync), 32'd0);
         if (n == 756)   chk("hs_after_low", 32'(hsync), 32'd1);
         if (n == 4192)  chk("rd_before_first", 32'(mem_rd), 32'd0);
         if (n == 4193) begin
            chk("rd_first", 32'(mem_rd), 32'd1);
            chk("addr_first", 32'(mem_addr), 32'd0);
         end
         if (n == 4196)  chk("rgb_first", 32'(rgb_out), 32'h5A5A5A);
         if (n == 8448) begin
            chk("rd_last_img0", 32'(mem_rd), 32'd1);
            chk("addr_last_img0", 32'(mem_addr), 32'd1535);
         end
         if (n == 21793) begin
            chk("rd_first_img1", 32'(mem_rd), 32'd1);
            chk("addr_first_img1", 32'(mem_addr), 32'd65536);
         end
         if (!hsync && hs_p) begin
            if (hs_last >= 0) chk("hs_period", 32'(n - hs_last), 32'd800);
            hs_last = n;
         end
         if (!vsync && vs_p) vs_cnt = 1;
         else if (!vsync && vs_cnt > 0) vs_cnt++;
         else if (vsync && !vs_p && vs_cnt > 0) begin
            chk("vs_low_len", 32'(vs_cnt), 32'd1600);
            vs_cnt = 0;
         end
         if (frame_start) begin
            if (fs_last >= 0) chk("fs_period", 32'(n - fs_last), 32'(FRAME));
            fs_last = n;
         end
         hs_p = hsync;
         vs_p = vsync;
      end
      rst_prev = rst;
      en_prev  = en;
      sel_prev = image_select;
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; en = 1; image_select = 0; ff_mode = 0;
      salt = 8'($urandom);
      repeat (3) @(posedge clk);
      #1 rst = 0;
      step(6000);
      image_select = 1;
      step(12000);
      for (int i = 0; i < 17200; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if (i % 700 == 0) image_select = 1'($urandom_range(0, 1));
         step(1);
      end
      ff_mode = 1; en = 0;
      step(FRAME);
      ff_mode = 0; en = 1;
      for (int i = 0; i < 6700; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if (i % 500 == 0) image_select = 1'($urandom_range(0, 1));
         step(1);
      end
      rst = 1; en = 1;
      step(2);
      rst = 0;
      step(4400);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
